fir_sequencer: RTL and testbench

Sequences the shared per-band FIR datapaths of the equalizer. Each new stereo sample strobe `vld` from the I2S receiver writes the sample into a circular sample RAM and, once NUM_TAPS samples are held, opens one `sequencing` window. The window supplies read addresses aligned to the FIR's registered coefficient ROM, then flags the finished convolution with `out_vld`. The block owns only addresses and timing; the sample RAM and FIR band instances sit outside it.

---
 rtl/eq_pkg.sv | 14 +
 rtl/fir_sequencer.sv | 153 +++++++++++++++
 tb/tb_fir_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer definitions: sequencer state encoding and default
// filter/sample-buffer dimensions.
package eq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEQ  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int NUM_TAPS_B   = 1023;
   localparam int SAMPLE_DEPTH = 1024;

endpackage

// File: rtl/fir_sequencer.sv
// Address and timing sequencer for the shared per-band FIR datapaths: writes
// incoming samples into a circular RAM and opens one convolution window per full buffer.
module fir_sequencer
   import eq_pkg::*;
#(
   parameter int NUM_TAPS = NUM_TAPS_B,
   parameter int DEPTH    = SAMPLE_DEPTH,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vld,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              sequencing,
   output logic              out_vld,
   output logic              full,
   output logic              overrun
);

   localparam int CNT_W  = $clog2(NUM_TAPS + 2);
   localparam int FILL_W = $clog2(NUM_TAPS + 1);

   localparam logic [FILL_W-1:0] TAPS_F   = FILL_W'(NUM_TAPS);
   localparam logic [FILL_W-1:0] LAST_F   = FILL_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(NUM_TAPS + 1);
   localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(NUM_TAPS - 1);
   localparam logic [ADDR_W-1:0] WRAP_TOP = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] wptr;
   logic [FILL_W-1:0] fill;

   logic              req;
   logic [ADDR_W-1:0] req_base;
   logic              pend;
   logic [ADDR_W-1:0] pend_base;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  cnt;

   seq_state_t        state;
   seq_state_t        state_nxt;

   logic              seq_d;
   logic              done_d;
   logic              start;
   logic [ADDR_W-1:0] start_base;

   // Write side runs independently of the window FSM; fill saturates so the
   // buffer stays full once NUM_TAPS samples have been seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wptr    <= '0;
         fill    <= '0;
         full    <= 1'b0;
      end else begin
         wr_en <= vld;
         if (vld) begin
            wr_addr <= wptr;
            wptr    <= (wptr == WRAP_TOP) ? '0 : wptr + 1'b1;
            if (fill != TAPS_F) begin
               fill <= fill + 1'b1;
            end
            if (fill == LAST_F) begin
               full <= 1'b1;
            end
         end
      end
   end

   // A write that leaves the buffer full asks for a window whose oldest
   // sample (coefficient 0) sits NUM_TAPS-1 slots behind the new one.
   assign req      = wr_en & full;
   assign req_base = wr_addr - SPAN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req || pend) begin
               state_nxt = SEQ;
            end
         end
         SEQ: begin
            if (cnt == LAST_C) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = pend ? SEQ : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A pending request takes priority out of DONE so windows can run
   // back to back; the newest request always supplies the base.
   always_comb begin
      seq_d      = (state_nxt == SEQ);
      done_d     = (state_nxt == DONE);
      start      = (state != SEQ) && (state_nxt == SEQ);
      start_base = req ? req_base : pend_base;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sequencing <= 1'b0;
         out_vld    <= 1'b0;
         rd_addr    <= '0;
         base       <= '0;
         cnt        <= '0;
         pend       <= 1'b0;
         pend_base  <= '0;
         overrun    <= 1'b0;
      end else begin
         sequencing <= seq_d;
         out_vld    <= done_d;

         if (start) begin
            cnt     <= '0;
            rd_addr <= start_base;
            base    <= start_base;
         end else if (state == SEQ) begin
            cnt     <= cnt + 1'b1;
            rd_addr <= base + ADDR_W'(cnt);
         end

         if (start) begin
            pend <= 1'b0;
         end else if (req) begin
            pend      <= 1'b1;
            pend_base <= req_base;
         end

         if (req && pend) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: a cycle-level window model on a small
// configuration, literal window checks, and a default-size impulse run.
module tb_fir_sequencer;

   localparam int N   = 5;
   localparam int D   = 8;
   localparam int AW  = 3;
   localparam int BN  = 1023;
   localparam int IMP = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vld = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          sequencing;
   logic          out_vld;
   logic          full;
   logic          overrun;

   logic          b_vld = 1'b0;
   logic          b_wr_en;
   logic [9:0]    b_wr_addr;
   logic [9:0]    b_rd_addr;
   logic          b_seq;
   logic          b_out_vld;
   logic          b_full;
   logic          b_overrun;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   fir_sequencer #(.NUM_TAPS(N), .DEPTH(D), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .vld(vld), .wr_en(wr_en), .wr_addr(wr_addr),
      .rd_addr(rd_addr), .sequencing(sequencing), .out_vld(out_vld),
      .full(full), .overrun(overrun)
   );

   fir_sequencer dut_big (
      .clk(clk), .rst_n(rst_n), .vld(b_vld), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .rd_addr(b_rd_addr), .sequencing(b_seq), .out_vld(b_out_vld),
      .full(b_full), .overrun(b_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // Window model: a window is a position 0..N+1 of sequencing followed by
   // one out_vld cycle; requests arriving mid-window wait, newest wins.
   int m_wptr = 0, m_fill = 0, m_pos = -1, m_base = 0, m_pend_base = 0, m_req_base = 0;
   bit m_req = 0, m_pend = 0;
   int e_wr_en = 0, e_wr_addr = 0, e_full = 0, e_ov = 0, e_seq = 0, e_rd = 0, e_out = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_wptr = 0; m_fill = 0; m_pos = -1; m_base = 0; m_pend_base = 0;
            m_req = 0; m_pend = 0; m_req_base = 0;
            e_wr_en = 0; e_wr_addr = 0; e_full = 0; e_ov = 0; e_seq = 0; e_rd = 0; e_out = 0;
         end else begin
            if (m_pos < 0) begin
               if (m_req && m_pend) e_ov = 1;
               if (m_req || m_pend) begin
                  m_base = m_req ? m_req_base : m_pend_base;
                  m_pend = 0;
                  m_pos = 0;
               end
            end else if (m_pos <= N + 1) begin
               if (m_req) begin
                  if (m_pend) e_ov = 1;
                  m_pend = 1;
                  m_pend_base = m_req_base;
               end
               m_pos++;
            end else begin
               if (m_pend) begin
                  if (m_req) e_ov = 1;
                  m_base = m_req ? m_req_base : m_pend_base;
                  m_pend = 0;
                  m_pos = 0;
               end else begin
                  if (m_req) begin
                     m_pend = 1;
                     m_pend_base = m_req_base;
                  end
                  m_pos = -1;
               end
            end
            m_req = 0;
            if (vld) begin
               e_wr_en = 1;
               e_wr_addr = m_wptr;
               m_wptr = (m_wptr + 1) % D;
               if (m_fill < N) m_fill++;
               if (m_fill == N) begin
                  m_req = 1;
                  m_req_base = (e_wr_addr - (N - 1) + D) % D;
               end
            end else begin
               e_wr_en = 0;
            end
            e_full = (m_fill == N) ? 1 : 0;
            e_seq  = (m_pos >= 0 && m_pos <= N + 1) ? 1 : 0;
            e_rd   = (m_pos == 0) ? m_base : (m_base + m_pos - 1) % D;
            e_out  = (m_pos == N + 2) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check_output("wr_en", wr_en, e_wr_en);
         check_output("full", full, e_full);
         check_output("overrun", overrun, e_ov);
         check_output("sequencing", sequencing, e_seq);
         check_output("out_vld", out_vld, e_out);
         if (e_wr_en != 0) check_output("wr_addr", wr_addr, e_wr_addr);
         if (e_seq != 0) check_output("rd_addr", rd_addr, e_rd);
      end
   end

   logic          seq_log [1024];
   logic          ov_log  [1024];
   logic [AW-1:0] rd_log  [1024];

   always @(negedge clk) begin
      if (cyc < 1024) begin
         seq_log[cyc] <= sequencing;
         ov_log[cyc]  <= out_vld;
         rd_log[cyc]  <= rd_addr;
      end
   end

   // Impulse-response harness for the default-size instance: sample RAM and
   // one FIR band with a registered coefficient ROM, coef(k) = 3k + 7.
   int ram_b [1024];
   int b_wcount = 0;
   int ram_q = 0, coef_q = 0, acc = 0, fcnt = 0;

   function automatic int coef(input int k);
      return 3 * k + 7;
   endfunction

   always @(posedge clk) begin
      if (b_wr_en) begin
         ram_b[b_wr_addr] <= (b_wcount == IMP) ? 1 : 0;
         b_wcount <= b_wcount + 1;
      end
      ram_q <= ram_b[b_rd_addr];
      if (b_seq) begin
         fcnt   <= fcnt + 1;
         coef_q <= coef(fcnt - 1);
         if (fcnt == 0) acc <= 0;
         else if (fcnt >= 2) acc <= acc + ram_q * coef_q;
      end else begin
         fcnt <= 0;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_stimulus(input int exp_addr, output int t);
      @(negedge clk);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      t = cyc - 1;
      check_output("wr_en_lit", wr_en, 1);
      check_output("wr_addr_lit", wr_addr, exp_addr);
   endtask

   function automatic int count_rises(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) begin
         if (seq_log[i] && !seq_log[i-1]) n++;
      end
      return n;
   endfunction

   // exp holds the seven window read addresses, one per nibble, first at the top.
   task automatic check_window(input string name, input int rise, input logic [27:0] exp);
      check_output({name, "_pre"}, seq_log[rise-1], 0);
      for (int i = 0; i < 7; i++) begin
         check_output({name, "_seq"}, seq_log[rise+i], 1);
         check_output({name, "_rd"}, rd_log[rise+i], int'(exp[(6-i)*4 +: 4]));
         check_output({name, "_ovl"}, ov_log[rise+i], 0);
      end
      check_output({name, "_end"}, seq_log[rise+7], 0);
      check_output({name, "_outvld"}, ov_log[rise+7], 1);
   endtask

   initial begin
      #300000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int t, t6, a0, last, seen;
      repeat (3) @(negedge clk);
      check_output("rst_wr_en", wr_en, 0);
      check_output("rst_wr_addr", wr_addr, 0);
      check_output("rst_rd_addr", rd_addr, 0);
      check_output("rst_seq", sequencing, 0);
      check_output("rst_out_vld", out_vld, 0);
      check_output("rst_full", full, 0);
      check_output("rst_overrun", overrun, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] four samples, buffer not yet full");
      a0 = cyc;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i, t);
         wait_cycles(1);
      end
      wait_cycles(4);
      check_output("partial_full", full, 0);
      check_output("partial_rises", count_rises(a0 + 1, cyc - 1), 0);

      $display("[TB] first window and a queued second window");
      apply_stimulus(4, t);
      wait_cycles(1);
      apply_stimulus(5, t6);
      wait_cycles(20);
      check_window("win1", t + 2, 28'h0012345);
      check_window("win2", t + 10, 28'h1123456);
      check_output("no_overrun", overrun, 0);

      $display("[TB] pointer wrap");
      apply_stimulus(6, t);
      wait_cycles(12);
      apply_stimulus(7, t);
      wait_cycles(12);
      apply_stimulus(0, t);
      wait_cycles(12);
      apply_stimulus(1, t);
      wait_cycles(12);
      check_window("wrap", t + 2, 28'h5567012);

      $display("[TB] three requests inside one window");
      apply_stimulus(2, t);
      apply_stimulus(3, t6);
      apply_stimulus(4, t6);
      apply_stimulus(5, t6);
      wait_cycles(22);
      check_window("ovr_first", t + 2, 28'h6670123);
      check_window("ovr_follow", t + 10, 28'h1123456);
      check_output("ovr_flag", overrun, 1);
      check_output("ovr_one_follow", count_rises(t + 3, t + 28), 1);

      $display("[TB] reset in the middle of a window");
      apply_stimulus(6, t);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("mid_rst_wr_en", wr_en, 0);
      check_output("mid_rst_wr_addr", wr_addr, 0);
      check_output("mid_rst_rd_addr", rd_addr, 0);
      check_output("mid_rst_seq", sequencing, 0);
      check_output("mid_rst_out_vld", out_vld, 0);
      check_output("mid_rst_full", full, 0);
      check_output("mid_rst_overrun", overrun, 0);
      check_output("mid_rst_was_active", seq_log[t + 4], 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      a0 = cyc;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i, t);
         wait_cycles(1);
      end
      wait_cycles(6);
      check_output("refill_rises", count_rises(a0 + 1, cyc - 1), 0);
      check_output("refill_full", full, 0);
      apply_stimulus(4, t);
      wait_cycles(12);
      check_window("post_reset", t + 2, 28'h0012345);

      $display("[TB] default size impulse response");
      @(negedge clk);
      b_vld = 1'b1;
      repeat (BN) @(negedge clk);
      b_vld = 1'b0;
      last = cyc - 1;
      check_output("big_full", b_full, 1);
      seen = 0;
      for (int i = 0; i < 1100 && seen == 0; i++) begin
         @(negedge clk);
         if (b_out_vld) seen = 1;
      end
      check_output("big_out_vld_seen", seen, 1);
      if (seen != 0) begin
         check_output("big_latency", cyc - last, 1027);
         check_output("big_fir_result", acc, 307);
      end
      check_output("big_overrun", b_overrun, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
